// File: rtl/img_wb_if.sv
// img_wb_if: pixel stream input and Wishbone write bus of img_wb_loader.
interface img_wb_if;
  logic        s_valid_i, s_ready_o;
  logic [31:0] s_data_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, readorg_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  modport master (
    input  s_valid_i, s_data_i, wb_ack_i,
    output s_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, readorg_o
  );
  modport slave (
    output s_valid_i, s_data_i, wb_ack_i,
    input  s_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, readorg_o
  );
endinterface

// File: rtl/img_wb_loader.sv
// img_wb_loader: buffers a pixel-word stream in a FIFO and writes one frame
// into the sobel input bank over Wishbone at sequential word addresses.
module img_wb_loader #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [21:0] BASE_ADDR   = 22'h000000,
  parameter int          FRAME_WORDS = 76800
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  img_wb_if.master    bus,
  output logic        busy_o,
  output logic        done_o,
  output logic [17:0] word_cnt_o
);
  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [18:0] FW_C   = 19'(FRAME_WORDS);
  // a full 2^18 frame wraps the 18-bit count to 0, which still matches here
  localparam logic [17:0] END_C  = 18'(FRAME_WORDS);
  typedef enum logic [1:0] {IDLE, RUN, REQ, GAP} state_e;
  state_e        state_q, state_d;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [18:0]   acc_q, acc_d;
  logic [17:0]   wcnt_q, wcnt_d;
  logic [21:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          cyc_q, cyc_d, busy_q, busy_d, done_q, done_d;
  logic          push, pop;
  assign bus.s_ready_o = busy_q && cnt_q != FULL_C && acc_q < FW_C;
  assign push          = bus.s_valid_i && bus.s_ready_o;
  assign pop           = state_q == REQ && bus.wb_ack_i;
  always_comb begin
    state_d = state_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    acc_d   = acc_q + 19'(push);
    wcnt_d  = wcnt_q + 18'(pop);
    adr_d   = pop ? adr_q + 22'd4 : adr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        rd_d    = '0;
        wr_d    = '0;
        cnt_d   = '0;
        acc_d   = '0;
        wcnt_d  = '0;
        adr_d   = BASE_ADDR;
        busy_d  = 1'b1;
      end
      RUN: if (cnt_q != '0) begin
        state_d = REQ;
        dat_d   = mem[rd_q];
        cyc_d   = 1'b1;
      end
      REQ: if (bus.wb_ack_i) begin
        state_d = GAP;
        cyc_d   = 1'b0;
      end
      default: begin
        state_d = wcnt_q == END_C ? IDLE : RUN;
        busy_d  = wcnt_q != END_C;
        done_d  = wcnt_q == END_C;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      adr_q   <= BASE_ADDR;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  always_ff @(posedge clk_i)
    if (push) mem[wr_q] <= bus.s_data_i;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = cyc_q;
  assign bus.readorg_o = cyc_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign word_cnt_o    = wcnt_q;
endmodule

// File: tb/tb_img_wb_loader.sv
// tb_img_wb_loader: random stream and Wishbone slave around img_wb_loader,
// checked every cycle against a queue-based model of the frame transfer.
module tb_img_wb_loader;
  localparam int          FW    = 16;
  localparam int          DEPTH = 8;
  localparam logic [21:0] BASE  = 22'h000100;
  logic        clk = 0, rst_n = 0, start = 0;
  logic        busy, done;
  logic [17:0] wcnt;
  img_wb_if bus ();
  img_wb_loader #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .FRAME_WORDS(FW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done), .word_cnt_o(wcnt)
  );
  always #5 clk = ~clk;
  int vectors = 0, errors = 0;
  int done_cnt = 0, dut_acc = 0, stall = 0;
  logic src_on = 0, hold = 0, spur_en = 0;
  logic [31:0] acc_dat[$], log_dat[$];
  logic [21:0] log_adr[$];
  // Model: words queue up while there is room and the frame quota is not used;
  // the bus writes the oldest word, then stays quiet one cycle after each ack.
  logic [31:0] m_q[$];
  int          m_acc, m_wr;
  logic        m_busy, m_cyc, m_gap, m_done;
  logic [31:0] m_dat;
  function automatic logic m_ready();
    return m_busy && m_q.size() < DEPTH && m_acc < FW;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_acc = 0; m_wr = 0; m_busy = 0; m_cyc = 0; m_gap = 0; m_done = 0; m_dat = 0;
    end else begin
      automatic logic        push = bus.s_valid_i && m_ready();
      automatic logic [31:0] d    = bus.s_data_i;
      m_done = 0;
      if (!m_busy) begin
        if (start) begin m_busy = 1; m_acc = 0; m_wr = 0; m_q.delete(); end
      end else if (m_cyc) begin
        if (bus.wb_ack_i) begin void'(m_q.pop_front()); m_wr++; m_cyc = 0; m_gap = 1; end
      end else if (m_gap) begin
        m_gap = 0;
        if (m_wr == FW) begin m_busy = 0; m_done = 1; end
      end else if (m_q.size() > 0) begin
        m_cyc = 1; m_dat = m_q[0];
      end
      if (push) begin m_q.push_back(d); m_acc++; end
    end
  end
  always @(negedge clk) begin
    automatic logic [78:0] got = {bus.s_ready_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                                  bus.readorg_o, busy, done, wcnt, bus.wb_adr_o, bus.wb_dat_o};
    automatic logic [78:0] exp = {m_ready(), m_cyc, m_cyc, m_cyc, m_cyc, m_busy, m_done,
                                  18'(m_wr), BASE + 22'(4 * m_wr), m_dat};
    vectors++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL outputs t=%0t {rdy,cyc,stb,we,rorg,busy,done,cnt,adr,dat} got=%h exp=%h",
                 $time, got, exp);
    end
    if (bus.s_valid_i && bus.s_ready_o) begin dut_acc++; acc_dat.push_back(bus.s_data_i); end
    if (done) done_cnt++;
  end
  always @(posedge clk) begin
    automatic logic c = (bus.wb_cyc_o && bus.wb_stb_o) === 1'b1;
    automatic logic a = bus.wb_ack_i === 1'b1;
    if (c && a) begin log_adr.push_back(bus.wb_adr_o); log_dat.push_back(bus.wb_dat_o); end
    #1;
    if (c && !a && stall > 0) begin
      stall--;
      bus.wb_ack_i = 0;
    end else
      bus.wb_ack_i = (c && !a) || (spur_en && !bus.wb_cyc_o && $urandom_range(0, 2) == 0);
  end
  always @(posedge clk) begin
    #1;
    bus.s_valid_i = src_on && (hold || $urandom_range(0, 9) < 7);
    bus.s_data_i  = $urandom;
  end
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic clear_logs();
    log_adr.delete(); log_dat.delete(); acc_dat.delete();
    done_cnt = 0; dut_acc = 0;
  endtask
  task automatic wait_done(int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (done !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL done_timeout waited=%0d cycles done_o=%b required 1", n, done);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic frame_check(string n);
    int k;
    chk({n, "_done_pulses"}, done_cnt, 1);
    chk({n, "_word_cnt"}, 32'(wcnt), FW);
    chk({n, "_accepted"}, dut_acc, FW);
    chk({n, "_writes"}, log_adr.size(), FW);
    k = log_adr.size() < acc_dat.size() ? log_adr.size() : acc_dat.size();
    for (int i = 0; i < k; i++) begin
      chk({n, "_adr"}, 32'(log_adr[i]), 32'(BASE) + 32'(4 * i));
      chk({n, "_dat"}, log_dat[i], acc_dat[i]);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cyc", 32'(bus.wb_cyc_o), 0);
    chk("reset_adr", 32'(bus.wb_adr_o), 32'h100);
    chk("reset_cnt", 32'(wcnt), 0);
    // frame 1: random valid, slave acks one cycle after cyc&stb
    src_on = 1;
    clear_logs();
    pulse_start();
    wait_done(2000);
    frame_check("f1");
    chk("f1_model_wr", m_wr, 16);
    chk("f1_final_adr", 32'(bus.wb_adr_o), 32'h140);
    // frame 2: valid held high, first ack stalled, second start ignored
    clear_logs();
    hold = 1;
    stall = 20;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("stall_accepts", dut_acc, 8);
    chk("stall_ready", 32'(bus.s_ready_o), 0);
    chk("stall_cnt", 32'(wcnt), 0);
    wait_done(2000);
    frame_check("f2");
    hold = 0;
    // frame 3: spurious acks while idle, in GAP and in RUN
    clear_logs();
    spur_en = 1;
    repeat (6) @(posedge clk);
    pulse_start();
    wait_done(2000);
    frame_check("f3");
    spur_en = 0;
    // asynchronous reset while a write is pending
    clear_logs();
    pulse_start();
    for (int n = 0; n < 100 && bus.wb_cyc_o !== 1'b1; n++) @(negedge clk);
    chk("pre_reset_cyc", 32'(bus.wb_cyc_o), 1);
    #2 rst_n = 0;
    #1;
    chk("async_cyc", 32'(bus.wb_cyc_o), 0);
    chk("async_stb", 32'(bus.wb_stb_o), 0);
    chk("async_readorg", 32'(bus.readorg_o), 0);
    @(posedge clk); #1 rst_n = 1;
    chk("abort_no_done", done_cnt, 0);
    chk("rst_cnt", 32'(wcnt), 0);
    chk("rst_adr", 32'(bus.wb_adr_o), 32'h100);
    clear_logs();
    pulse_start();
    wait_done(2000);
    frame_check("f4");
    src_on = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
